flag_cond_unit: RTL

- Consumer end of the add/sub-with-flags datapath. It captures result/carry/overflow/zero from the adder into an architectural NZCV flag register and answers condition-code queries (ARM-style 4-bit codes) with a valid/ready handshake.
- It feeds the stored carry back as carry-in for multi-word (ADC/SBC) chains.
- It sits between the ALU flag outputs and the branch/predication logic.

---
 rtl/flag_cond_pkg.sv | 73 +++++++
 rtl/flag_cond_if.sv | 65 ++++++
 rtl/flag_cond_eval.sv | 15 +
 rtl/flag_cond_unit.sv | 120 ++++++++++++
 4 files changed

// File: rtl/flag_cond_pkg.sv
// flag_cond_pkg: shared definitions for the NZCV flag / condition-code unit.
//   - CC_EQ..CC_NV : ARM-style 4-bit condition codes
//   - FLAG_N/Z/C/V : bit positions inside the packed {N,Z,C,V} flag word
//   - resp_state_t : response register occupancy
//   - cond_eval()  : pure condition-code evaluator, shared by RTL users
package flag_cond_pkg;

  localparam int unsigned CC_W   = 4;
  localparam int unsigned NZCV_W = 4;

  localparam logic [CC_W-1:0] CC_EQ = 4'h0;
  localparam logic [CC_W-1:0] CC_NE = 4'h1;
  localparam logic [CC_W-1:0] CC_CS = 4'h2;
  localparam logic [CC_W-1:0] CC_CC = 4'h3;
  localparam logic [CC_W-1:0] CC_MI = 4'h4;
  localparam logic [CC_W-1:0] CC_PL = 4'h5;
  localparam logic [CC_W-1:0] CC_VS = 4'h6;
  localparam logic [CC_W-1:0] CC_VC = 4'h7;
  localparam logic [CC_W-1:0] CC_HI = 4'h8;
  localparam logic [CC_W-1:0] CC_LS = 4'h9;
  localparam logic [CC_W-1:0] CC_GE = 4'hA;
  localparam logic [CC_W-1:0] CC_LT = 4'hB;
  localparam logic [CC_W-1:0] CC_GT = 4'hC;
  localparam logic [CC_W-1:0] CC_LE = 4'hD;
  localparam logic [CC_W-1:0] CC_AL = 4'hE;
  localparam logic [CC_W-1:0] CC_NV = 4'hF;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic {
    RESP_EMPTY = 1'b0,
    RESP_FULL  = 1'b1
  } resp_state_t;

  // Evaluate a condition code against a {N,Z,C,V} flag word.
  function automatic logic cond_eval(input logic [CC_W-1:0]   code,
                                     input logic [NZCV_W-1:0] flags);
    logic n;
    logic z;
    logic c;
    logic v;
    logic r;
    n = flags[FLAG_N];
    z = flags[FLAG_Z];
    c = flags[FLAG_C];
    v = flags[FLAG_V];
    r = 1'b0;
    case (code)
      CC_EQ: r = z;
      CC_NE: r = ~z;
      CC_CS: r = c;
      CC_CC: r = ~c;
      CC_MI: r = n;
      CC_PL: r = ~n;
      CC_VS: r = v;
      CC_VC: r = ~v;
      CC_HI: r = c & ~z;
      CC_LS: r = ~c | z;
      CC_GE: r = (n == v);
      CC_LT: r = (n != v);
      CC_GT: r = ~z & (n == v);
      CC_LE: r = z | (n != v);
      CC_AL: r = 1'b1;
      CC_NV: r = 1'b0;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/flag_cond_if.sv
// flag_cond_if: bundle between the ALU/branch side and flag_cond_unit.
//   flg_*   : flag-update channel from the adder (valid/ready, ready tied high)
//   cc_*    : condition query channel (valid/ready)
//   resp_*  : query response channel (valid/ready)
//   nzcv, carry_chain : architectural flag state observed by the datapath
//   q_clear, sticky_q : only with FLAG_COND_STICKY_Q_EN (sticky overflow)
// Modports: master = requester side, slave = flag_cond_unit.
interface flag_cond_if #(
  parameter int unsigned WIDTH = 32
);
  import flag_cond_pkg::*;

  logic              flg_valid;
  logic              flg_ready;
  logic [WIDTH-1:0]  flg_result;
  logic              flg_carry;
  logic              flg_overflow;
  logic              flg_zero;
  logic              flg_chain;

  logic              cc_valid;
  logic              cc_ready;
  logic [CC_W-1:0]   cc_code;

  logic              resp_valid;
  logic              resp_ready;
  logic              resp_taken;

  logic [NZCV_W-1:0] nzcv;
  logic              carry_chain;

`ifdef FLAG_COND_STICKY_Q_EN
  logic              q_clear;
  logic              sticky_q;
`endif

  modport master (
`ifdef FLAG_COND_STICKY_Q_EN
    output q_clear,
    input  sticky_q,
`endif
    output flg_valid, flg_result, flg_carry, flg_overflow, flg_zero, flg_chain,
    input  flg_ready,
    output cc_valid, cc_code,
    input  cc_ready,
    input  resp_valid, resp_taken,
    output resp_ready,
    input  nzcv, carry_chain
  );

  modport slave (
`ifdef FLAG_COND_STICKY_Q_EN
    input  q_clear,
    output sticky_q,
`endif
    input  flg_valid, flg_result, flg_carry, flg_overflow, flg_zero, flg_chain,
    output flg_ready,
    input  cc_valid, cc_code,
    output cc_ready,
    output resp_valid, resp_taken,
    input  resp_ready,
    output nzcv, carry_chain
  );

endinterface

// File: rtl/flag_cond_eval.sv
// flag_cond_eval: combinational condition-code decoder.
//   code    : 4-bit condition code
//   flags   : {N,Z,C,V}
//   taken_c : condition holds
module flag_cond_eval
  import flag_cond_pkg::*;
(
  input  logic [CC_W-1:0]   code,
  input  logic [NZCV_W-1:0] flags,
  output logic              taken_c
);

  assign taken_c = cond_eval(code, flags);

endmodule

// File: rtl/flag_cond_unit.sv
// flag_cond_unit: architectural NZCV register plus condition-code query port.
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   bus (slave)   : flg_* update channel, cc_* query channel, resp_* response
//                   channel, nzcv / carry_chain flag state
// Optional build macro FLAG_COND_STICKY_Q_EN adds q_clear / sticky_q, a sticky
// overflow bit set by any accepted write with overflow and cleared by q_clear.
module flag_cond_unit
  import flag_cond_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  flag_cond_if.slave  bus
);

  resp_state_t       resp_state;
  logic [NZCV_W-1:0] nzcv_q;
  logic              resp_taken_q;

  logic              flg_fire_c;
  logic              cc_ready_c;
  logic              cc_fire_c;
  logic              z_next_c;
  logic [NZCV_W-1:0] flags_next_c;
  logic [NZCV_W-1:0] flags_fwd_c;
  logic              taken_c;
  logic              unused_result_bits;

  // Writes are never stalled.
  assign bus.flg_ready = 1'b1;
  assign flg_fire_c    = bus.flg_valid;

  // Only the sign bit of the result is architecturally visible.
  assign unused_result_bits = ^bus.flg_result[WIDTH-2:0];

  // One-entry response register: accept whenever it is empty or draining.
  assign cc_ready_c = (resp_state == RESP_EMPTY) || bus.resp_ready;
  assign cc_fire_c  = bus.cc_valid && cc_ready_c;

  // Next flag word; Z accumulates across the words of a multi-word op.
  always_comb begin
    z_next_c     = bus.flg_chain ? (nzcv_q[FLAG_Z] & bus.flg_zero) : bus.flg_zero;
    flags_next_c = '0;
    flags_next_c[FLAG_N] = bus.flg_result[WIDTH-1];
    flags_next_c[FLAG_Z] = z_next_c;
    flags_next_c[FLAG_C] = bus.flg_carry;
    flags_next_c[FLAG_V] = bus.flg_overflow;
  end

  // A query sees a write accepted in the same cycle.
  assign flags_fwd_c = flg_fire_c ? flags_next_c : nzcv_q;

  flag_cond_eval u_eval (
    .code    (bus.cc_code),
    .flags   (flags_fwd_c),
    .taken_c (taken_c)
  );

  // Flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nzcv_q <= '0;
    end else if (flg_fire_c) begin
      nzcv_q <= flags_next_c;
    end
  end

  // Response register FSM; resp_taken only changes when a new query lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_state   <= RESP_EMPTY;
      resp_taken_q <= 1'b0;
    end else begin
      case (resp_state)
        RESP_EMPTY: begin
          if (cc_fire_c) begin
            resp_state   <= RESP_FULL;
            resp_taken_q <= taken_c;
          end
        end
        RESP_FULL: begin
          if (cc_fire_c) begin
            resp_state   <= RESP_FULL;
            resp_taken_q <= taken_c;
          end else if (bus.resp_ready) begin
            resp_state   <= RESP_EMPTY;
          end
        end
        default: begin
          resp_state <= RESP_EMPTY;
        end
      endcase
    end
  end

  assign bus.cc_ready    = cc_ready_c;
  assign bus.resp_valid  = (resp_state == RESP_FULL);
  assign bus.resp_taken  = resp_taken_q;
  assign bus.nzcv        = nzcv_q;
  assign bus.carry_chain = nzcv_q[FLAG_C];

`ifdef FLAG_COND_STICKY_Q_EN
  logic sticky_q_r;

  // Sticky overflow: a same-cycle set overrides the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q_r <= 1'b0;
    end else if (flg_fire_c && bus.flg_overflow) begin
      sticky_q_r <= 1'b1;
    end else if (bus.q_clear) begin
      sticky_q_r <= 1'b0;
    end
  end

  assign bus.sticky_q = sticky_q_r;
`endif

endmodule
